// File: rtl/axi_mm2s_pkg.sv
// Shared definitions for the axi_mm2s family: FSM state encoding, status and
// result bit positions, and control-beat field layout.
// No ports (package).
package axi_mm2s_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_DRAIN  = 2'd2,
        S_RESULT = 2'd3
    } mm2s_state_t;

    // Status byte returned per chunk by axi_mm2s
    localparam int unsigned ST_ERR = 0;

    // Aggregated result byte
    localparam int unsigned RES_ERR  = 0;
    localparam int unsigned RES_WRAP = 1;

    // Control beat layout: {chunk_len[15:0], chunk_addr}
    localparam int unsigned CTL_ADDR_LSB  = 0;
    localparam int unsigned CTL_LEN_WIDTH = 16;

    // The length field sits directly above the address field.
    function automatic int unsigned ctl_len_lsb(input int unsigned addr_width);
        return addr_width;
    endfunction

endpackage

// File: rtl/axi_mm2s_split_if.sv
// Stream bundle for axi_mm2s_split.
//   s_axis_req_*  : request in  {len, addr}
//   m_axis_ctl_*  : chunk command out {chunk_len[15:0], chunk_addr}
//   s_axis_st_*   : per-chunk status in (bit0 = read error)
//   m_axis_res_*  : aggregated result out
// Modport master is the splitter side, slave is the attached environment.
interface axi_mm2s_split_if #(
    parameter int unsigned C_AXI_ADDR_WIDTH = 64,
    parameter int unsigned C_REQ_LEN_WIDTH  = 32
);

    logic [C_REQ_LEN_WIDTH+C_AXI_ADDR_WIDTH-1:0]                     s_axis_req_tdata;
    logic                                                            s_axis_req_tvalid;
    logic                                                            s_axis_req_tready;

    logic [C_AXI_ADDR_WIDTH+axi_mm2s_pkg::CTL_LEN_WIDTH-1:0]         m_axis_ctl_tdata;
    logic                                                            m_axis_ctl_tvalid;
    logic                                                            m_axis_ctl_tready;

    logic [7:0]                                                      s_axis_st_tdata;
    logic                                                            s_axis_st_tvalid;
    logic                                                            s_axis_st_tready;

    logic [7:0]                                                      m_axis_res_tdata;
    logic                                                            m_axis_res_tvalid;
    logic                                                            m_axis_res_tready;

    modport master (
        input  s_axis_req_tdata, s_axis_req_tvalid,
        output s_axis_req_tready,
        output m_axis_ctl_tdata, m_axis_ctl_tvalid,
        input  m_axis_ctl_tready,
        input  s_axis_st_tdata, s_axis_st_tvalid,
        output s_axis_st_tready,
        output m_axis_res_tdata, m_axis_res_tvalid,
        input  m_axis_res_tready
    );

    modport slave (
        output s_axis_req_tdata, s_axis_req_tvalid,
        input  s_axis_req_tready,
        input  m_axis_ctl_tdata, m_axis_ctl_tvalid,
        output m_axis_ctl_tready,
        output s_axis_st_tdata, s_axis_st_tvalid,
        input  s_axis_st_tready,
        input  m_axis_res_tdata, m_axis_res_tvalid,
        output m_axis_res_tready
    );

endinterface

// File: rtl/axi_mm2s_chunk_calc.sv
// Combinational chunk sizing: the next chunk is the smaller of the bytes
// remaining and the bytes left before the next C_MAX_CHUNK-aligned boundary.
//   addr_lo     in  low 16 address bits (enough for any chunk size up to 32768)
//   remaining   in  bytes still to issue
//   chunk_len   out chunk length; 32768 encodes naturally as 16'h8000
module axi_mm2s_chunk_calc #(
    parameter int unsigned C_REQ_LEN_WIDTH = 32,
    parameter int unsigned C_MAX_CHUNK     = 4096
) (
    input  logic [15:0]                addr_lo,
    input  logic [C_REQ_LEN_WIDTH-1:0] remaining,
    output logic [15:0]                chunk_len
);

    localparam logic [15:0] OFF_MASK = 16'(C_MAX_CHUNK - 1);
    localparam logic [16:0] CHUNK_SZ = 17'(C_MAX_CHUNK);

    logic [16:0] room;

    assign room = CHUNK_SZ - {1'b0, addr_lo & OFF_MASK};

    always_comb begin
        if (remaining < C_REQ_LEN_WIDTH'(room)) begin
            chunk_len = remaining[15:0];
        end else begin
            chunk_len = room[15:0];
        end
    end

endmodule

// File: rtl/axi_mm2s_split.sv
// Request splitter in front of axi_mm2s. One {len, addr} request is cut into
// chunks that never cross a C_MAX_CHUNK boundary; at most C_MAX_OUTSTANDING
// chunks are in flight without a returned status. One result byte per request:
// bit0 = any chunk error, bit1 = rejected because addr+len wraps the space.
//   clk, rst_n  clock, asynchronous active-low reset
//   bus         stream bundle (master modport)
//   busy        high whenever the FSM is not idle
module axi_mm2s_split
    import axi_mm2s_pkg::*;
#(
    parameter int unsigned C_AXI_ADDR_WIDTH  = 64,
    parameter int unsigned C_REQ_LEN_WIDTH   = 32,
    parameter int unsigned C_MAX_CHUNK       = 4096,
    parameter int unsigned C_MAX_OUTSTANDING = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    axi_mm2s_split_if.master     bus,
    output logic                 busy
);

    localparam int unsigned AW          = C_AXI_ADDR_WIDTH;
    localparam int unsigned LW          = C_REQ_LEN_WIDTH;
    localparam int unsigned OW          = $clog2(C_MAX_OUTSTANDING + 1);
    localparam int unsigned CW          = AW + CTL_LEN_WIDTH;
    localparam int unsigned CTL_LEN_LSB = ctl_len_lsb(AW);
    localparam logic [OW-1:0] OUT_MAX   = OW'(C_MAX_OUTSTANDING);

    mm2s_state_t   state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [LW-1:0] rem_q, rem_d;
    logic [OW-1:0] out_q, out_d;
    logic          err_q, err_d;
    logic          req_ready_q, req_ready_d;
    logic          ctl_valid_q, ctl_valid_d;
    logic [CW-1:0] ctl_data_q, ctl_data_d;
    logic          res_valid_q, res_valid_d;
    logic [7:0]    res_data_q, res_data_d;

    logic          req_hs, ctl_hs, st_hs, res_hs;
    logic [AW-1:0] req_addr;
    logic [LW-1:0] req_len;
    logic [AW:0]   req_end;
    logic          req_wrap;
    logic [15:0]   ctl_len_q;
    logic [15:0]   next_chunk;

    assign req_hs = req_ready_q & bus.s_axis_req_tvalid;
    assign ctl_hs = ctl_valid_q & bus.m_axis_ctl_tready;
    assign st_hs  = (out_q != '0) & bus.s_axis_st_tvalid;
    assign res_hs = res_valid_q & bus.m_axis_res_tready;

    assign req_addr = bus.s_axis_req_tdata[AW-1:0];
    assign req_len  = bus.s_axis_req_tdata[AW+LW-1:AW];

    // Reject when the request ends beyond the top of the address space:
    // addr+len > 2^AW, i.e. carry set and any low bit set.
    assign req_end  = {1'b0, req_addr} + (AW+1)'(req_len);
    assign req_wrap = req_end[AW] & (req_end[AW-1:0] != '0);

    assign ctl_len_q = ctl_data_q[CTL_LEN_LSB +: CTL_LEN_WIDTH];

    // Sized from the next-cycle addr/remaining so the registered beat is ready
    // the cycle after a handshake; the beat just accepted advances addr/remaining
    // by its own registered length.
    axi_mm2s_chunk_calc #(
        .C_REQ_LEN_WIDTH (LW),
        .C_MAX_CHUNK     (C_MAX_CHUNK)
    ) u_chunk_calc (
        .addr_lo   (addr_d[15:0]),
        .remaining (rem_d),
        .chunk_len (next_chunk)
    );

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rem_d      = rem_q;
        err_d      = err_q | (st_hs & bus.s_axis_st_tdata[ST_ERR]);
        res_valid_d = res_valid_q;
        res_data_d = res_data_q;

        unique case ({ctl_hs, st_hs})
            2'b10:   out_d = out_q + OW'(1);
            2'b01:   out_d = out_q - OW'(1);
            default: out_d = out_q;
        endcase

        case (state_q)
            S_IDLE: begin
                if (req_hs) begin
                    addr_d = req_addr;
                    rem_d  = req_len;
                    err_d  = 1'b0;
                    if (req_len == '0) begin
                        state_d     = S_RESULT;
                        res_valid_d = 1'b1;
                        res_data_d  = '0;
                    end else if (req_wrap) begin
                        state_d              = S_RESULT;
                        res_valid_d          = 1'b1;
                        res_data_d           = '0;
                        res_data_d[RES_WRAP] = 1'b1;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (ctl_hs) begin
                    addr_d = addr_q + AW'(ctl_len_q);
                    rem_d  = rem_q - LW'(ctl_len_q);
                    if (rem_d == '0) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (out_d == '0) begin
                    state_d             = S_RESULT;
                    res_valid_d         = 1'b1;
                    res_data_d          = '0;
                    res_data_d[RES_ERR] = err_d;
                end
            end
            S_RESULT: begin
                if (res_hs) begin
                    state_d     = S_IDLE;
                    res_valid_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        ctl_valid_d = (state_d == S_ISSUE) && (out_d < OUT_MAX);
        ctl_data_d  = '0;
        ctl_data_d[CTL_ADDR_LSB +: AW]           = addr_d;
        ctl_data_d[CTL_LEN_LSB +: CTL_LEN_WIDTH] = next_chunk;
        req_ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            rem_q       <= '0;
            out_q       <= '0;
            err_q       <= 1'b0;
            req_ready_q <= 1'b0;
            ctl_valid_q <= 1'b0;
            ctl_data_q  <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            out_q       <= out_d;
            err_q       <= err_d;
            req_ready_q <= req_ready_d;
            ctl_valid_q <= ctl_valid_d;
            ctl_data_q  <= ctl_data_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
        end
    end

    assign bus.s_axis_req_tready = req_ready_q;
    assign bus.m_axis_ctl_tvalid = ctl_valid_q;
    assign bus.m_axis_ctl_tdata  = ctl_data_q;
    assign bus.s_axis_st_tready  = (out_q != '0);
    assign bus.m_axis_res_tvalid = res_valid_q;
    assign bus.m_axis_res_tdata  = res_data_q;
    assign busy                  = (state_q != S_IDLE);

endmodule

// File: tb/tb_axi_mm2s_split.sv
// Self-checking bench for axi_mm2s_split: table of requests run through a
// scoreboard (expected ctl beats and result bytes queued when a request is
// driven), plus hand-written sequences for timing, the outstanding limit and
// reset. Inputs are driven and outputs sampled on the falling clock edge.
module tb_axi_mm2s_split;

    localparam int unsigned AW    = 64;
    localparam int unsigned LW    = 32;
    localparam int unsigned CHUNK = 4096;
    localparam int unsigned MAXO  = 4;

    typedef struct {
        logic [79:0] data;
        logic [7:0]  st;
    } ctl_exp_t;

    typedef struct {
        logic [63:0] addr;
        logic [31:0] len;
        logic [31:0] err_mask;
        int unsigned beats;
        logic [7:0]  res;
        logic        rand_bp;
    } vec_t;

    logic clk;
    logic rst_n;
    logic busy;

    axi_mm2s_split_if #(.C_AXI_ADDR_WIDTH(AW), .C_REQ_LEN_WIDTH(LW)) bus ();

    axi_mm2s_split #(
        .C_AXI_ADDR_WIDTH  (AW),
        .C_REQ_LEN_WIDTH   (LW),
        .C_MAX_CHUNK       (CHUNK),
        .C_MAX_OUTSTANDING (MAXO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .busy  (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    ctl_exp_t    exp_ctl_q[$];
    logic [7:0]  exp_res_q[$];
    logic [7:0]  st_q[$];

    int unsigned n_cmp;
    int unsigned n_bad;
    int unsigned ctl_beats;

    logic        ctl_rand, res_rand, ctl_rdy_fix, res_rdy_fix, st_hold;
    int unsigned st_budget;

    logic        req_seen, s_ctl_valid, s_res_valid, s_req_ready, s_busy;
    logic        prev_ctl_pend, prev_res_pend;
    logic [79:0] prev_ctl_data;
    logic [7:0]  prev_res_data;

    vec_t        vecs[10];

    function automatic void check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endfunction

    function automatic void flag(input string name, input logic [127:0] act);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got 0x%0h, want nothing", name, act);
    endfunction

    // Expected beats for one request, built from the chunking rule.
    task automatic push_model(input logic [63:0] addr, input logic [31:0] len, input logic [31:0] mask);
        logic [64:0] sum;
        logic [63:0] a;
        logic [31:0] r, room, c;
        int unsigned idx;
        ctl_exp_t    e;
        sum = {1'b0, addr} + {33'b0, len};
        if (len == 0 || sum > {1'b1, 64'h0}) return;
        a   = addr;
        r   = len;
        idx = 0;
        while (r != 0) begin
            room   = 32'(CHUNK) - 32'(a & 64'(CHUNK - 1));
            c      = (r < room) ? r : room;
            e.data = {c[15:0], a};
            e.st   = {7'($urandom), mask[idx]};
            exp_ctl_q.push_back(e);
            a   = a + 64'(c);
            r   = r - c;
            idx++;
        end
    endtask

    // One clock: drive ready/status at the falling edge, predict and score the
    // handshakes of the following rising edge, return just after it.
    task automatic cycle();
        logic     ctl_hs, st_hs, res_hs;
        ctl_exp_t e;
        logic [7:0] r;
        @(negedge clk);
        bus.m_axis_ctl_tready = ctl_rand ? 1'($urandom_range(0, 1)) : ctl_rdy_fix;
        bus.m_axis_res_tready = res_rand ? 1'($urandom_range(0, 1)) : res_rdy_fix;
        if (st_q.size() > 0 && (!st_hold || st_budget > 0)) begin
            bus.s_axis_st_tvalid = 1'b1;
            bus.s_axis_st_tdata  = st_q[0];
        end else begin
            bus.s_axis_st_tvalid = 1'b0;
            bus.s_axis_st_tdata  = 8'($urandom);
        end

        if (prev_ctl_pend) begin
            check("ctl_hold_valid", bus.m_axis_ctl_tvalid, 1'b1);
            check("ctl_hold_data", bus.m_axis_ctl_tdata, prev_ctl_data);
        end
        if (prev_res_pend) begin
            check("res_hold_valid", bus.m_axis_res_tvalid, 1'b1);
            check("res_hold_data", bus.m_axis_res_tdata, prev_res_data);
        end

        s_ctl_valid = bus.m_axis_ctl_tvalid;
        s_res_valid = bus.m_axis_res_tvalid;
        s_req_ready = bus.s_axis_req_tready;
        s_busy      = busy;

        ctl_hs   = bus.m_axis_ctl_tvalid && bus.m_axis_ctl_tready;
        st_hs    = bus.s_axis_st_tvalid && bus.s_axis_st_tready;
        res_hs   = bus.m_axis_res_tvalid && bus.m_axis_res_tready;
        req_seen = bus.s_axis_req_tvalid && bus.s_axis_req_tready;

        if (st_hs) begin
            st_q.delete(0);
            if (st_hold && st_budget > 0) st_budget--;
        end
        if (ctl_hs) begin
            ctl_beats++;
            if (exp_ctl_q.size() == 0) begin
                flag("ctl_unexpected", bus.m_axis_ctl_tdata);
                st_q.push_back(8'h00);
            end else begin
                e = exp_ctl_q.pop_front();
                check("ctl_beat", bus.m_axis_ctl_tdata, e.data);
                st_q.push_back(e.st);
            end
        end
        if (res_hs) begin
            if (exp_res_q.size() == 0) begin
                flag("res_unexpected", bus.m_axis_res_tdata);
            end else begin
                r = exp_res_q.pop_front();
                check("res_byte", bus.m_axis_res_tdata, r);
            end
        end

        prev_ctl_pend = bus.m_axis_ctl_tvalid && !ctl_hs;
        prev_ctl_data = bus.m_axis_ctl_tdata;
        prev_res_pend = bus.m_axis_res_tvalid && !res_hs;
        prev_res_data = bus.m_axis_res_tdata;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [63:0] addr, input logic [31:0] len);
        int unsigned k;
        bus.s_axis_req_tdata  = {len, addr};
        bus.s_axis_req_tvalid = 1'b1;
        k = 0;
        do begin
            cycle();
            k++;
        end while (!req_seen && k < 100);
        bus.s_axis_req_tvalid = 1'b0;
        if (!req_seen) flag("req_timeout", k);
    endtask

    task automatic wait_done(input int unsigned bound);
        int unsigned k;
        k = 0;
        while ((exp_ctl_q.size() != 0 || exp_res_q.size() != 0 || st_q.size() != 0) && k < bound) begin
            cycle();
            k++;
        end
        if (k >= bound) begin
            flag("done_timeout", exp_ctl_q.size() + exp_res_q.size() + st_q.size());
            exp_ctl_q.delete();
            exp_res_q.delete();
            st_q.delete();
        end
    endtask

    task automatic run_vec(input int unsigned i, input vec_t v);
        int unsigned b0;
        ctl_rand    = v.rand_bp;
        res_rand    = v.rand_bp;
        ctl_rdy_fix = 1'b1;
        res_rdy_fix = 1'b1;
        st_hold     = 1'b0;
        push_model(v.addr, v.len, v.err_mask);
        exp_res_q.push_back(v.res);
        b0 = ctl_beats;
        issue(v.addr, v.len);
        wait_done(3000);
        check($sformatf("vec%0d_beats", i), ctl_beats - b0, v.beats);
    endtask

    // Zero-length or rejected request: result valid the very next cycle.
    task automatic quick_result(input string name, input logic [63:0] addr, input logic [31:0] len, input logic [7:0] res);
        ctl_rand    = 1'b0;
        res_rand    = 1'b0;
        ctl_rdy_fix = 1'b1;
        res_rdy_fix = 1'b0;
        exp_res_q.push_back(res);
        issue(addr, len);
        cycle();
        check({name, "_res_valid_n1"}, s_res_valid, 1'b1);
        check({name, "_no_ctl"}, s_ctl_valid, 1'b0);
        res_rdy_fix = 1'b1;
        wait_done(20);
    endtask

    initial begin
        int unsigned b0;
        int unsigned k;
        ctl_exp_t    e;

        n_cmp = 0; n_bad = 0; ctl_beats = 0;
        ctl_rand = 1'b0; res_rand = 1'b0; ctl_rdy_fix = 1'b1; res_rdy_fix = 1'b1;
        st_hold = 1'b0; st_budget = 0;
        req_seen = 1'b0; s_ctl_valid = 1'b0; s_res_valid = 1'b0; s_req_ready = 1'b0; s_busy = 1'b0;
        prev_ctl_pend = 1'b0; prev_res_pend = 1'b0; prev_ctl_data = '0; prev_res_data = '0;

        bus.s_axis_req_tdata  = '0;
        bus.s_axis_req_tvalid = 1'b0;
        bus.m_axis_ctl_tready = 1'b0;
        bus.s_axis_st_tdata   = '0;
        bus.s_axis_st_tvalid  = 1'b0;
        bus.m_axis_res_tready = 1'b0;

        //             addr                   len           mask   beats res    rand
        vecs[0] = '{64'h0000_0000_0000_1000, 32'h0000_1000, 32'h0,  1, 8'h00, 1'b0};
        vecs[1] = '{64'h0000_0000_2000_0000, 32'h0000_3000, 32'h2,  3, 8'h01, 1'b0};
        vecs[2] = '{64'h0000_0000_0000_0123, 32'h0000_0010, 32'h0,  1, 8'h00, 1'b1};
        vecs[3] = '{64'h0000_0000_0000_0ABC, 32'h0000_0000, 32'h0,  0, 8'h00, 1'b1};
        vecs[4] = '{64'hFFFF_FFFF_FFFF_F000, 32'h0000_2000, 32'h0,  0, 8'h02, 1'b1};
        vecs[5] = '{64'h0000_0000_0000_5000, 32'h0000_6000, 32'h20, 6, 8'h01, 1'b1};
        vecs[6] = '{64'h0000_0000_0000_0FFF, 32'h0000_0002, 32'h0,  2, 8'h00, 1'b1};
        vecs[7] = '{64'h0000_0000_0000_0000, 32'h0001_1000, 32'h0, 17, 8'h00, 1'b1};
        vecs[8] = '{64'h0000_0000_7FFF_0800, 32'h0000_1800, 32'h3,  2, 8'h01, 1'b1};
        vecs[9] = '{64'hFFFF_FFFF_FFFF_FFFF, 32'h0000_0002, 32'h0,  0, 8'h02, 1'b0};

        // Reset state
        rst_n = 1'b0;
        #22;
        check("rst_req_ready", bus.s_axis_req_tready, 1'b0);
        check("rst_ctl_valid", bus.m_axis_ctl_tvalid, 1'b0);
        check("rst_res_valid", bus.m_axis_res_tvalid, 1'b0);
        check("rst_st_ready", bus.s_axis_st_tready, 1'b0);
        check("rst_busy", busy, 1'b0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cycle();
        check("idle_req_ready", s_req_ready, 1'b1);

        // Boundary split against literal beats
        e.st = 8'h00;
        e.data = {16'h0100, 64'h0000_0000_1000_0F00}; exp_ctl_q.push_back(e);
        e.data = {16'h1000, 64'h0000_0000_1000_1000}; exp_ctl_q.push_back(e);
        e.data = {16'h1000, 64'h0000_0000_1000_2000}; exp_ctl_q.push_back(e);
        e.data = {16'h0100, 64'h0000_0000_1000_3000}; exp_ctl_q.push_back(e);
        exp_res_q.push_back(8'h00);
        b0 = ctl_beats;
        issue(64'h0000_0000_1000_0F00, 32'h2200);
        wait_done(200);
        check("split_beats", ctl_beats - b0, 4);

        // First beat at N+1, held under backpressure, ready returns after result
        ctl_rdy_fix = 1'b0;
        res_rdy_fix = 1'b0;
        push_model(64'h3000, 32'h180, 32'h0);
        exp_res_q.push_back(8'h00);
        issue(64'h3000, 32'h180);
        cycle();
        check("first_ctl_n1", s_ctl_valid, 1'b1);
        check("busy_issue", s_busy, 1'b1);
        check("req_ready_busy", s_req_ready, 1'b0);
        repeat (3) cycle();
        ctl_rdy_fix = 1'b1;
        k = 0;
        do begin
            cycle();
            k++;
        end while (!s_res_valid && k < 50);
        if (!s_res_valid) flag("res_wait_timeout", k);
        repeat (2) cycle();
        res_rdy_fix = 1'b1;
        cycle();
        cycle();
        check("req_ready_after_res", s_req_ready, 1'b1);
        check("busy_after_res", s_busy, 1'b0);
        wait_done(20);

        // Zero length and address wrap
        quick_result("zero_len", 64'h40, 32'h0, 8'h00);
        quick_result("wrap", 64'hFFFF_FFFF_FFFF_F000, 32'h2000, 8'h02);

        // Outstanding limit with statuses withheld
        ctl_rand = 1'b0; res_rand = 1'b0; ctl_rdy_fix = 1'b1; res_rdy_fix = 1'b1;
        st_hold = 1'b1; st_budget = 0;
        push_model(64'h0, 32'h6000, 32'h0);
        exp_res_q.push_back(8'h00);
        b0 = ctl_beats;
        issue(64'h0, 32'h6000);
        repeat (8) cycle();
        check("limit_beats", ctl_beats - b0, MAXO);
        check("limit_valid_low", s_ctl_valid, 1'b0);
        st_budget = 1;
        cycle();
        st_budget = 1;
        cycle();
        check("fifth_valid_next", s_ctl_valid, 1'b1);
        check("fifth_beat", ctl_beats - b0, 5);
        cycle();
        check("same_cycle_keeps_count", s_ctl_valid, 1'b1);
        st_hold = 1'b0;
        wait_done(200);
        check("limit_total_beats", ctl_beats - b0, 6);

        // Table-driven requests
        for (int unsigned i = 0; i < 10; i++) begin
            run_vec(i, vecs[i]);
        end

        // Reset in the middle of ISSUE
        ctl_rand = 1'b0; ctl_rdy_fix = 1'b1; res_rand = 1'b0; res_rdy_fix = 1'b1;
        st_hold = 1'b1; st_budget = 0;
        push_model(64'h4000_0000, 32'h8000, 32'h0);
        exp_res_q.push_back(8'h00);
        issue(64'h4000_0000, 32'h8000);
        repeat (2) cycle();
        check("pre_reset_busy", s_busy, 1'b1);
        check("pre_reset_ctl_valid", s_ctl_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ctl_valid", bus.m_axis_ctl_tvalid, 1'b0);
        check("mid_rst_res_valid", bus.m_axis_res_tvalid, 1'b0);
        check("mid_rst_req_ready", bus.s_axis_req_tready, 1'b0);
        check("mid_rst_st_ready", bus.s_axis_st_tready, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        exp_ctl_q.delete();
        exp_res_q.delete();
        st_q.delete();
        prev_ctl_pend = 1'b0;
        prev_res_pend = 1'b0;
        st_hold = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_vec(100, vecs[5]);
        run_vec(101, vecs[1]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/axi_mm2s_split.md
# axi_mm2s_split

Request splitter that sits directly upstream of `axi_mm2s`. It accepts one large read request (address plus 32-bit byte count) and cuts it into chunks that never cross a `C_MAX_CHUNK`-aligned boundary. Each chunk goes out as a control beat on `axi_mm2s`'s control stream. The block tracks outstanding chunks against the status bytes that come back and returns one aggregated result byte per request.

## Interface
- `C_AXI_ADDR_WIDTH`, 64: address width; matches `axi_mm2s`.
- `C_REQ_LEN_WIDTH`, 32: request byte-count width.
- `C_MAX_CHUNK`, 4096: chunk size and boundary in bytes; power of two, 1..32768.
- `C_MAX_OUTSTANDING`, 4: maximum number of chunks issued without a returned status; at least 1.
- `clk`  in  1  single clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `s_axis_req_tdata`  in  `C_REQ_LEN_WIDTH+C_AXI_ADDR_WIDTH`  `{len, addr}`; addr is in the low bits.
- `s_axis_req_tvalid` / `s_axis_req_tready`  in/out  1  request handshake.
- `m_axis_ctl_tdata`  out  `C_AXI_ADDR_WIDTH+16`  `{chunk_len[15:0], chunk_addr}`; goes to `axi_mm2s` `s_axis_ctl`.
- `m_axis_ctl_tvalid` / `m_axis_ctl_tready`  out/in  1.
- `s_axis_st_tdata`  in  8  per-chunk status from `axi_mm2s`; bit0=read error, other bits ignored.
- `s_axis_st_tvalid` / `s_axis_st_tready`  in/out  1.
- `m_axis_res_tdata`  out  8  bit0=any chunk error, bit1=request rejected (address wrap), bits 7:2=0.
- `m_axis_res_tvalid` / `m_axis_res_tready`  out/in  1.
- `busy`  out  1  high in every state except IDLE.

## Operation
- States: IDLE, ISSUE, DRAIN, RESULT.
- IDLE:
  - `s_axis_req_tready`=1. On handshake, latch addr, len, clear the error flag, then go to ISSUE.
  - len=0: skip to RESULT with 0x00.
  - addr+len > 2^`C_AXI_ADDR_WIDTH` (carry out of the width-extended sum): go to RESULT with 0x02 and issue no commands.
- ISSUE:
  - Chunk length = min(remaining, `C_MAX_CHUNK` − (addr mod `C_MAX_CHUNK`)).
  - `m_axis_ctl_tvalid` is asserted only while outstanding < `C_MAX_OUTSTANDING`.
  - On handshake: addr += chunk, remaining −= chunk, outstanding += 1.
  - When remaining reaches 0, go to DRAIN.
- Status input:
  - `s_axis_st_tready`=1 whenever outstanding > 0, in any state.
  - On handshake: outstanding −= 1 and error |= tdata[0].
  - A ctl handshake and a status handshake in the same cycle leave outstanding unchanged.
- DRAIN: when outstanding=0, go to RESULT with `{6'b0, 1'b0, error}`.
- RESULT:
  - `m_axis_res_tvalid`=1 with tdata stable until `m_axis_res_tready`.
  - On handshake, go to IDLE.
- Width rules:
  - Outstanding counter is `$clog2(C_MAX_OUTSTANDING+1)` bits.
  - A chunk length equal to `C_MAX_CHUNK`=32768 encodes as 0x8000 in the 16-bit field.
  - Address arithmetic is in `C_AXI_ADDR_WIDTH` bits.
- Reset (asynchronous, any state): all tvalid=0, `s_axis_req_tready`=0, `busy`=0, counters cleared, state=IDLE. Status bytes for in-flight chunks are discarded. The system resets `axi_mm2s` together with this block.

## Timing
- Request handshake in cycle N: first `m_axis_ctl_tvalid` in cycle N+1.
- ctl tdata/tvalid are registered.
- With ready held high and the outstanding limit not reached, the block issues one chunk per cycle (next beat valid the cycle after each handshake).
- The result becomes valid the cycle after the final status handshake, or after entering DRAIN when outstanding is already 0.
- Zero-length or rejected request handshake in cycle N: result valid in N+1.
- `s_axis_req_tready` returns to 1 the cycle after the result handshake.
- ctl and res tvalid never drop without a handshake, and tdata stays stable while tvalid=1.

## Structure
- Package `axi_mm2s_pkg`, shared with `axi_mm2s`, holds:
  - state encoding;
  - status bit positions (ST_ERR=0) and result bit positions (RES_ERR=0, RES_WRAP=1);
  - ctl field offsets.
- Sub-module `axi_mm2s_chunk_calc`: combinational boundary/min computation of the chunk length from addr and remaining. The FSM and counters stay in the top module.

## Test plan
- Boundary split: `C_MAX_CHUNK`=4096, req addr 0x10000F00 len 0x2200 -> ctl beats (0x10000F00,0x100), (0x10001000,0x1000), (0x10002000,0x1000), (0x10003000,0x100); four 0x00 statuses -> result 0x00.
- Outstanding limit: `C_MAX_OUTSTANDING`=4, 6-chunk request, status withheld -> exactly 4 ctl beats then tvalid=0; one status returned -> 5th beat valid the next cycle. Same-cycle ctl and status handshakes keep the count unchanged.
- Error aggregation: second of three statuses = 0x01 -> result 0x01.
- Zero length and wrap:
  - len 0 -> no ctl beat, result 0x00 at N+1.
  - addr 0xFFFFFFFFFFFFF000, len 0x2000 -> no ctl beat, result 0x02.
- Backpressure and reset:
  - `m_axis_ctl_tready` and `m_axis_res_tready` toggled randomly -> tdata stable while valid, no beat lost.
  - `rst_n` low mid-ISSUE -> all valid=0 immediately; after release, a new request processes correctly.
